// File: rtl/radix4_seq_mult_pkg.sv
// Shared types for the digit-serial radix-4 multiplier: mode/state encodings,
// digit-control struct and the per-digit recoder used by the top.
package radix4_seq_mult_pkg;

  typedef enum logic [1:0] {
    MODE_MB     = 2'd0,
    MODE_NR4SDM = 2'd1,
    MODE_NR4SDP = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // one/two select |d|; neg marks a negative digit (row inverted, +1 injected)
  typedef struct packed {
    logic one;
    logic two;
    logic neg;
  } digit_ctrl_t;

  typedef struct packed {
    digit_ctrl_t ctrl;
    logic        carry;
  } recode_t;

  // b1:b0 is the current bit pair, bm the bit below it (MB only), cin the
  // carry from the previous NR4SD digit. The MSD of NR4SD absorbs the carry
  // with the signed top pair, so it never produces a carry out.
  function automatic recode_t recode_digit(input mode_e mode, input logic b1,
                                           input logic b0, input logic bm,
                                           input logic cin, input logic msd);
    recode_t          r;
    logic signed [2:0] d;
    logic [2:0]        v;
    r = '0;
    d = '0;
    v = {1'b0, b1, b0} + {2'b00, cin};
    if (mode == MODE_NR4SDM || mode == MODE_NR4SDP) begin
      if (msd) begin
        d = $signed({b1, b1, b0}) + $signed({2'b00, cin});
      end else begin
        case (v)
          3'd1: d = 3'sd1;
          3'd2: begin
            if (mode == MODE_NR4SDM) begin
              d       = -3'sd2;
              r.carry = 1'b1;
            end else begin
              d = 3'sd2;
            end
          end
          3'd3: begin
            d       = -3'sd1;
            r.carry = 1'b1;
          end
          3'd4: r.carry = 1'b1;
          default: d = 3'sd0;
        endcase
      end
    end else begin
      d = $signed({b1, b1, b0}) + $signed({2'b00, bm});
    end
    r.ctrl.one = (d == 3'sd1) || (d == -3'sd1);
    r.ctrl.two = (d == 3'sd2) || (d == -3'sd2);
    r.ctrl.neg = d[2];
    return r;
  endfunction

endpackage

// File: rtl/radix4_seq_mult_if.sv
// Operand/product handshake bundle for radix4_seq_mult.
interface radix4_seq_mult_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, mode, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, mode, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/radix4_pp_row.sv
// One radix-4 partial-product row: selects 0, a or 2a and conditionally
// inverts; the matching +1 is returned as neg for injection by the caller.
module radix4_pp_row
  import radix4_seq_mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  digit_ctrl_t      ctrl,
  output logic [WIDTH:0]   row,
  output logic             neg
);
  logic [WIDTH:0] mag;

  always_comb begin
    mag = '0;
    if (ctrl.one)      mag = {a[WIDTH-1], a};
    else if (ctrl.two) mag = {a, 1'b0};
    row = ctrl.neg ? ~mag : mag;
    neg = ctrl.neg;
  end
endmodule

// File: rtl/radix4_seq_mult.sv
// Sequential signed radix-4 multiplier: one recoded digit of b per RUN cycle,
// selectable MB / NR4SD- / NR4SD+ recoding, 2*WIDTH wrap-around accumulator.
module radix4_seq_mult
  import radix4_seq_mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  radix4_seq_mult_if.slave  bus
);
  localparam int NDIG  = WIDTH / 2;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int AW    = 2 * WIDTH;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bsh_q, bsh_d;
  logic             bprev_q, bprev_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;

  recode_t          rec;
  logic             msd;
  logic [WIDTH:0]   row;
  logic             row_neg;
  logic [CNT_W:0]   shamt;
  logic [AW-1:0]    row_ext;
  logic [AW-1:0]    term;

  assign msd   = (cnt_q == CNT_W'(NDIG - 1));
  assign shamt = {cnt_q, 1'b0};

  // b is consumed two bits per cycle from the bottom of bsh_q; bprev_q keeps
  // the bit just shifted out for the MB overlap
  assign rec = recode_digit(mode_q, bsh_q[1], bsh_q[0], bprev_q, carry_q, msd);

  radix4_pp_row #(.WIDTH(WIDTH)) u_row (
    .a    (a_q),
    .ctrl (rec.ctrl),
    .row  (row),
    .neg  (row_neg)
  );

  assign row_ext = {{(AW - WIDTH - 1){row[WIDTH]}}, row};
  assign term    = (row_ext << shamt) + (AW'(row_neg) << shamt);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    a_d     = a_q;
    bsh_d   = bsh_q;
    bprev_d = bprev_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          bsh_d   = bus.b;
          mode_d  = mode_e'(bus.mode);
          bprev_d = 1'b0;
          carry_d = 1'b0;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d   = acc_q + term;
        bsh_d   = bsh_q >> 2;
        bprev_d = bsh_q[1];
        carry_d = rec.carry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (msd) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_MB;
      a_q     <= '0;
      bsh_q   <= '0;
      bprev_q <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      bsh_q   <= bsh_d;
      bprev_q <= bprev_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign bus.product   = acc_q;
endmodule

// File: tb/tb_radix4_seq_mult.sv
// Scoreboard bench for radix4_seq_mult (WIDTH=16): directed corners plus
// random operands/modes with random consumer backpressure.
module tb_radix4_seq_mult;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  radix4_seq_mult_if #(.WIDTH(16)) bus ();

  radix4_seq_mult #(.WIDTH(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_issued = 0;
  int          n_done = 0;
  int          ready_mode = 0;  // 0: always ready, 1: random, 2: stalled
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[31:0];
  endfunction

  // consumer: out_ready changes just after the edge so the monitor sees a stable value
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(3) != 0);
      default: bus.out_ready = 1'b0;
    endcase
  end

  // monitor: every product handshake pops one expectation
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got %h with no pending operation", bus.product);
      end else begin
        chk("product", bus.product, exp_q.pop_front());
      end
      n_done++;
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] m, input logic [31:0] exp);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_timeout: in_ready stayed %b, expected 1", bus.in_ready);
      return;
    end
    bus.a = a;
    bus.b = b;
    bus.mode = m;
    bus.in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(exp);
    n_issued++;
    #1;
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    bus.mode = 2'($urandom);
  endtask

  // call right after issue(); counts cycles until out_valid
  task automatic wait_valid(output int lat);
    lat = 0;
    @(negedge clk);
    while (!bus.out_valid && lat < 50) begin
      chk("in_ready_run", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [15:0] ra, rb;
    logic [1:0]  rm;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.mode = '0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_product", bus.product, 32'd0);
    rst_n = 1'b1;

    for (int m = 0; m < 3; m++) begin
      issue(16'd7, 16'hFFFD, 2'(m), 32'hFFFFFFEB);
      wait_valid(lat);
      chk("latency", 32'(lat), 32'd8);
      chk("in_ready_done", 32'(bus.in_ready), 32'd0);
      chk("busy_done", 32'(bus.busy), 32'd1);
      drain();
      issue(16'h8000, 16'h8000, 2'(m), 32'h40000000);
      issue(16'h7FFF, 16'h7FFF, 2'(m), 32'h3FFF0001);
      issue(16'h8000, 16'h7FFF, 2'(m), 32'hC0008000);
      issue(16'h7FFF, 16'h8000, 2'(m), 32'hC0008000);
      drain();
    end

    // backpressure in DONE
    ready_mode = 2;
    @(posedge clk);
    #2;
    issue(16'h1234, 16'h5678, 2'd1, 32'h06260060);
    wait_valid(lat);
    repeat (5) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_product", bus.product, 32'h06260060);
    end
    ready_mode = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("release_out_valid", 32'(bus.out_valid), 32'd0);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    drain();

    // reset during RUN cycle 4 discards the operation
    issue(16'd1234, 16'd567, 2'd0, model(16'd1234, 16'd567));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    void'(exp_q.pop_back());
    n_issued--;
    @(negedge clk);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_product", bus.product, 32'd0);
    rst_n = 1'b1;
    issue(16'd3, 16'd5, 2'd2, 32'd15);
    drain();

    // reserved mode runs as MB; inputs are scrambled during RUN by issue()
    issue(16'h1234, 16'h5678, 2'd3, 32'h06260060);
    drain();

    ready_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(15))
        0: ra = 16'h8000;
        1: rb = 16'h8000;
        2: ra = 16'h7FFF;
        3: rb = 16'hFFFF;
        default: ;
      endcase
      rm = 2'($urandom_range(3));
      issue(ra, rb, rm, model(ra, rb));
    end
    ready_mode = 0;
    drain();
    chk("issue_vs_done", 32'(n_done), 32'(n_issued));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
